// File: rtl/mem_bus_responder.sv
// Single-outstanding bus responder: RAM, LED register, synced switches.
// Commit happens on the edge that enters RESP; ack pulses in RESP.
module mem_bus_responder #(
  parameter int DATA_W      = 16,
  parameter int RAM_AW      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int LED_W       = 9,
  parameter int SW_W        = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] dout,
  input  logic              w,
  output logic [DATA_W-1:0] din,
  output logic              ack,
  output logic              busy,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                w_q, w_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                err_q, err_d;
  logic [SW_W-1:0]     sw_s1_q, sw_s2_q;

  logic [DATA_W-1:0]   ram [2**RAM_AW];
  logic [RAM_AW-1:0]   ram_idx;
  logic                commit;
  logic                ram_we;
  logic                is_ram, is_led, is_sw, is_unm;
  logic                unused_addr;

  assign unused_addr = ^addr_d[11:RAM_AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    w_d     = w_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = dout;
          w_d     = w;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = WLOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decode uses the _d view so a zero-wait request commits from the inputs.
  always_comb begin
    is_ram  = 1'b0;
    is_led  = 1'b0;
    is_sw   = 1'b0;
    is_unm  = 1'b0;
    ram_idx = addr_d[RAM_AW-1:0];
    unique case (1'b1)
      (addr_d[15:12] == 4'h0): is_ram = 1'b1;
      (addr_d[15:12] == 4'h1): is_led = 1'b1;
      (addr_d[15:12] == 4'h3): is_sw  = 1'b1;
      default:                 is_unm = 1'b1;
    endcase
  end

  always_comb begin
    din_d  = din_q;
    led_d  = led_q;
    err_d  = err_q;
    ram_we = 1'b0;
    if (commit) begin
      if (is_unm) err_d = 1'b1;
      if (w_d) begin
        ram_we = is_ram;
        if (is_led) led_d = wdata_d[LED_W-1:0];
      end else begin
        unique case (1'b1)
          is_ram:  din_d = ram[ram_idx];
          is_led:  din_d = DATA_W'(led_q);
          is_sw:   din_d = DATA_W'(sw_s2_q);
          default: din_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      w_q     <= 1'b0;
      din_q   <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      w_q     <= w_d;
      din_q   <= din_d;
      led_q   <= led_d;
      err_q   <= err_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata_d;
  end

  assign din  = din_q;
  assign ack  = (state_q == S_RESP);
  assign busy = (state_q != S_IDLE);
  assign led  = led_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (0, 1 and 3 wait states)
// checked against a per-instance memory-map model.
module tb_mem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n [3];
  logic        req     [3];
  logic [15:0] addr    [3];
  logic [15:0] dout    [3];
  logic        w       [3];
  logic [15:0] din     [3];
  logic        ack     [3];
  logic        busy    [3];
  logic [8:0]  sw      [3];
  logic [8:0]  led     [3];
  logic        err     [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_bus_responder #(
        .DATA_W(16), .RAM_AW(8),
        .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
        .LED_W(9), .SW_W(9)
      ) u_dut (
        .clk(clk), .reset_n(reset_n[g]), .req(req[g]),
        .addr(addr[g]), .dout(dout[g]), .w(w[g]),
        .din(din[g]), .ack(ack[g]), .busy(busy[g]),
        .sw(sw[g]), .led(led[g]), .err(err[g])
      );
    end
  endgenerate

  logic [15:0] ram_m [3][256];
  logic [8:0]  led_m [3];
  logic [8:0]  sw_m  [3];
  logic        err_m [3];
  logic [15:0] din_m [3];
  int tests = 0;
  int fails = 0;

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic do_txn(input int k, input logic [15:0] a,
                        input logic [15:0] d, input logic wr);
    int n;
    bit bad;
    @(negedge clk);
    tests++;
    if (busy[k] !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy k=%0d got=%b exp=0", k, busy[k]);
    end
    req[k] = 1'b1; addr[k] = a; dout[k] = d; w[k] = wr;
    @(posedge clk); #1;
    req[k] = 1'b0;
    addr[k] = 16'($urandom); dout[k] = 16'($urandom); w[k] = 1'($urandom);
    n = 1; bad = 0;
    while (ack[k] !== 1'b1 && n < 40) begin
      if (busy[k] !== 1'b1) bad = 1;
      @(posedge clk); #1;
      n++;
    end
    case (a[15:12])
      4'h0: if (wr) ram_m[k][a[7:0]] = d; else din_m[k] = ram_m[k][a[7:0]];
      4'h1: if (wr) led_m[k] = d[8:0]; else din_m[k] = {7'b0, led_m[k]};
      4'h3: if (!wr) din_m[k] = {7'b0, sw_m[k]};
      default: begin
        err_m[k] = 1'b1;
        if (!wr) din_m[k] = 16'h0;
      end
    endcase
    tests++;
    if (n != wc_of(k) + 1 || ack[k] !== 1'b1) begin
      fails++;
      $display("FAIL latency k=%0d a=%h got=%0d exp=%0d", k, a, n, wc_of(k) + 1);
    end
    tests++;
    if (bad || busy[k] !== 1'b1) begin
      fails++;
      $display("FAIL busy_during k=%0d a=%h got=%b exp=1", k, a, busy[k]);
    end
    tests++;
    if (din[k] !== din_m[k]) begin
      fails++;
      $display("FAIL din k=%0d a=%h wr=%b got=%h exp=%h", k, a, wr, din[k], din_m[k]);
    end
    tests++;
    if (led[k] !== led_m[k]) begin
      fails++;
      $display("FAIL led k=%0d a=%h got=%h exp=%h", k, a, led[k], led_m[k]);
    end
    tests++;
    if (err[k] !== err_m[k]) begin
      fails++;
      $display("FAIL err k=%0d a=%h got=%b exp=%b", k, a, err[k], err_m[k]);
    end
    @(posedge clk); #1;
    tests++;
    if (ack[k] !== 1'b0 || busy[k] !== 1'b0) begin
      fails++;
      $display("FAIL ack_pulse k=%0d got=%b%b exp=00", k, ack[k], busy[k]);
    end
  endtask

  task automatic test_reset_state();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({din[k], ack[k], busy[k], led[k], err[k]} !== 28'h0) begin
        fails++;
        $display("FAIL reset_state k=%0d got=%h/%b/%b/%h/%b exp=0",
                 k, din[k], ack[k], busy[k], led[k], err[k]);
      end
    end
  endtask

  task automatic preload();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        do_txn(k, 16'(i), 16'($urandom), 1'b1);
  endtask

  task automatic test_reset();
    do_txn(2, 16'h1000, 16'h0155, 1'b1);
    do_txn(2, 16'h0005, 16'h1111, 1'b1);
    @(negedge clk);
    req[2] = 1'b1; addr[2] = 16'h0005; dout[2] = 16'hDEAD; w[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    reset_n[2] = 1'b0;
    #1;
    led_m[2] = '0; din_m[2] = '0; err_m[2] = 1'b0;
    tests++;
    if (ack[2] !== 1'b0 || busy[2] !== 1'b0 || led[2] !== 9'h0) begin
      fails++;
      $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", ack[2], busy[2], led[2]);
    end
    @(negedge clk);
    reset_n[2] = 1'b1;
    do_txn(2, 16'h0005, 16'h0, 1'b0);
  endtask

  task automatic test_ram_roundtrip();
    for (int k = 0; k < 2; k++) begin
      do_txn(k, 16'h0005, 16'hBEEF, 1'b1);
      do_txn(k, 16'h0005, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_alias();
    do_txn(1, 16'h0105, 16'h1234, 1'b1);
    do_txn(1, 16'h0005, 16'h0, 1'b0);
    do_txn(1, 16'h0F05, 16'h0, 1'b0);
  endtask

  task automatic test_led();
    do_txn(1, 16'h1000, 16'hFFFF, 1'b1);
    do_txn(1, 16'h0003, 16'h0, 1'b0);
    do_txn(1, 16'h1000, 16'h0, 1'b0);
  endtask

  task automatic test_switches();
    sw[0] = 9'h0A5; sw_m[0] = 9'h0A5;
    repeat (3) @(posedge clk);
    do_txn(0, 16'h3000, 16'h0, 1'b0);
    do_txn(0, 16'h3000, 16'hFFFF, 1'b1);
    do_txn(0, 16'h3000, 16'h0, 1'b0);
  endtask

  task automatic test_unmapped();
    do_txn(0, 16'h7000, 16'h0, 1'b0);
    do_txn(0, 16'h0005, 16'h0, 1'b0);
    do_txn(0, 16'h1000, 16'h0042, 1'b1);
  endtask

  task automatic test_busy_hold();
    int exp_q[$];
    int got_q[$];
    int nf;
    nf = 0;
    for (int t = 0; t < 6; t++) begin
      if (t >= nf) begin
        exp_q.push_back(t + wc_of(1) + 1);
        nf = t + wc_of(1) + 2;
      end
    end
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 16'h0005; w[1] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1) got_q.push_back(c);
      if (c == 6) req[1] = 1'b0;
    end
    din_m[1] = ram_m[1][5];
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL hold_ack_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] != exp_q[i]) begin
          fails++;
          $display("FAIL hold_ack_cycle got=%0d exp=%0d", got_q[i], exp_q[i]);
        end
      end
    end
    tests++;
    if (din[1] !== din_m[1]) begin
      fails++;
      $display("FAIL hold_din got=%h exp=%h", din[1], din_m[1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [3:0]  rg;
    int r, u;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 30; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 4) begin
          a = {4'h0, 4'($urandom), 4'h0, 4'($urandom_range(0, 15))};
        end else if (r <= 6) begin
          a = {4'h1, 12'($urandom)};
        end else if (r == 7) begin
          a = {4'h3, 12'($urandom)};
        end else if (r == 8) begin
          u = $urandom_range(0, 12);
          rg = (u == 0) ? 4'h2 : 4'(u + 3);
          a = {rg, 12'($urandom)};
        end else begin
          sw[k] = 9'($urandom); sw_m[k] = sw[k];
          repeat (3) @(posedge clk);
          a = {4'h3, 12'($urandom)};
        end
        do_txn(k, a, 16'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset_n[k] = 1'b0; req[k] = 1'b0; addr[k] = '0;
      dout[k] = '0; w[k] = 1'b0; sw[k] = '0;
      led_m[k] = '0; sw_m[k] = '0; err_m[k] = 1'b0; din_m[k] = '0;
    end
    #23;
    test_reset_state();
    @(negedge clk);
    for (int k = 0; k < 3; k++) reset_n[k] = 1'b1;
    preload();
    test_reset();
    test_ram_roundtrip();
    test_alias();
    test_led();
    test_switches();
    test_unmapped();
    test_busy_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
